// File: rtl/uart_rx_bit_sampler.sv
// UART RX bit-timing controller: synchronises the rx pin, validates the start
// bit and strobes each frame bit at mid-bit with a 3-sample majority vote.
// Also reports false starts, framing errors and line breaks.
module uart_rx_bit_sampler #(
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int FRAME_BITS = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_i,
  input  logic [DIV_W-1:0] baud_div_i,
  input  logic             rx_async_i,
  output logic             rx_sync_o,
  output logic             bit_strobe_o,
  output logic [3:0]       bit_index_o,
  output logic             bit_value_o,
  output logic             busy_o,
  output logic             start_err_o,
  output logic             frame_err_o,
  output logic             break_det_o
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] MID_LO  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] MID     = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0] MID_HI  = OS_W'(OVERSAMPLE / 2 + 1);
  localparam logic [3:0]      LAST_DATA_IDX = 4'(FRAME_BITS - 2);
  localparam logic [3:0]      STOP_IDX      = 4'(FRAME_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e           state_q, state_d;
  logic             sync1_q, sync2_q, rx_prev_q;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
  logic [1:0]       samp_q, samp_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic             all_zero_q, all_zero_d;
  logic             bit_strobe_q, bit_strobe_d;
  logic [3:0]       bit_index_q, bit_index_d;
  logic             bit_value_q, bit_value_d;
  logic             start_err_q, start_err_d;
  logic             frame_err_q, frame_err_d;
  logic             break_det_q, break_det_d;

  logic             os_tick, start_acc, is_samp, mid_done, vote;
  logic [DIV_W-1:0] reload;

  // Two-flop synchroniser for the raw pin plus a delayed copy for edge detection.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= rx_async_i;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
    end
  end

  // Decoded timing events; a divisor of 0 behaves like 1.
  always_comb begin
    reload    = (baud_div_i == '0) ? '0 : baud_div_i - DIV_W'(1);
    os_tick   = (presc_q == '0);
    start_acc = (state_q == IDLE) && enable_i && rx_prev_q && !sync2_q;
    is_samp   = os_tick && ((os_cnt_q == MID_LO) || (os_cnt_q == MID) ||
                            (os_cnt_q == MID_HI));
    mid_done  = os_tick && (os_cnt_q == MID_HI);
    vote      = (samp_q[1] & samp_q[0]) | (samp_q[1] & sync2_q) |
                (samp_q[0] & sync2_q);
  end

  // Next-state logic for the prescaler, oversample counter and bit FSM.
  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    presc_d      = (start_acc || os_tick) ? reload : presc_q - DIV_W'(1);
    os_cnt_d     = os_cnt_q;
    samp_d       = samp_q;
    bit_cnt_d    = bit_cnt_q;
    all_zero_d   = all_zero_q;
    bit_strobe_d = 1'b0;
    bit_index_d  = bit_index_q;
    bit_value_d  = bit_value_q;
    start_err_d  = 1'b0;
    frame_err_d  = 1'b0;
    break_det_d  = 1'b0;

    if (start_acc)    os_cnt_d = '0;
    else if (os_tick) os_cnt_d = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OS_W'(1);

    if (is_samp) samp_d = {samp_q[0], sync2_q};

    unique case (state_q)
      IDLE: if (start_acc) state_d = START;
      START: if (mid_done) begin
        if (!vote) begin
          bit_strobe_d = 1'b1;
          bit_index_d  = 4'd0;
          bit_value_d  = 1'b0;
          bit_cnt_d    = 4'd1;
          all_zero_d   = 1'b1;
          state_d      = DATA;
        end else begin
          start_err_d  = 1'b1;
          state_d      = IDLE;
        end
      end
      DATA: if (mid_done) begin
        bit_strobe_d = 1'b1;
        bit_index_d  = bit_cnt_q;
        bit_value_d  = vote;
        all_zero_d   = all_zero_q & ~vote;
        bit_cnt_d    = bit_cnt_q + 4'd1;
        if (bit_cnt_q == LAST_DATA_IDX) state_d = STOP;
      end
      STOP: if (mid_done) begin
        // Return to IDLE at mid-stop so a following start edge is not missed.
        bit_strobe_d = 1'b1;
        bit_index_d  = STOP_IDX;
        bit_value_d  = vote;
        frame_err_d  = !vote;
        break_det_d  = !vote && all_zero_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Disabling drops any partial frame silently.
    if (!enable_i) begin
      state_d      = IDLE;
      bit_strobe_d = 1'b0;
      bit_index_d  = bit_index_q;
      bit_value_d  = bit_value_q;
      start_err_d  = 1'b0;
      frame_err_d  = 1'b0;
      break_det_d  = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      os_cnt_q     <= '0;
      samp_q       <= 2'b11;
      bit_cnt_q    <= '0;
      all_zero_q   <= 1'b0;
      bit_strobe_q <= 1'b0;
      bit_index_q  <= '0;
      bit_value_q  <= 1'b1;
      start_err_q  <= 1'b0;
      frame_err_q  <= 1'b0;
      break_det_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      os_cnt_q     <= os_cnt_d;
      samp_q       <= samp_d;
      bit_cnt_q    <= bit_cnt_d;
      all_zero_q   <= all_zero_d;
      bit_strobe_q <= bit_strobe_d;
      bit_index_q  <= bit_index_d;
      bit_value_q  <= bit_value_d;
      start_err_q  <= start_err_d;
      frame_err_q  <= frame_err_d;
      break_det_q  <= break_det_d;
    end
  end

  assign rx_sync_o    = sync2_q;
  assign bit_strobe_o = bit_strobe_q;
  assign bit_index_o  = bit_index_q;
  assign bit_value_o  = bit_value_q;
  assign busy_o       = (state_q != IDLE);
  assign start_err_o  = start_err_q;
  assign frame_err_o  = frame_err_q;
  assign break_det_o  = break_det_q;

endmodule
